uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters; legal range 2..8.
REQ-002 Parameter DIV, default 10, uart_clk cycles per serial bit (100 MHz / 10 Mbps); legal minimum 2.
REQ-003 Parameter LINE_LOCK, default 1; 1 = hold grant until owner sends 0x0A, 0 = re-arbitrate every byte.
REQ-004 Port uart_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port req_valid  input  NREQ  bit i = requester i offers a byte.
REQ-007 Port req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-008 Port req_ready  output  NREQ  bit i = byte of requester i accepted this cycle.
REQ-009 Port tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-010 Port busy  output  1  high while a frame is in flight.
REQ-011 Port grant_id  output  max(1,$clog2(NREQ))  index of current or most recent owner.
REQ-012 Port locked  output  1  high while a line lock is held.

Function
REQ-013 FSM states IDLE, START, DATA, STOP; bit timer counts 0..DIV-1, bit index 0..7.
REQ-014 In IDLE with at least one eligible req_valid, exactly one req_ready bit SHALL assert for one cycle; the byte transfers on that edge (valid and ready both high).
REQ-015 req_ready SHALL be zero in every state other than IDLE and zero when no eligible request exists.
REQ-016 Eligible set: when locked=0, all i with req_valid[i]; when locked=1, only grant_id.
REQ-017 Unlocked selection SHALL be round-robin: search starts at grant_id+1 modulo NREQ, first set bit wins; after reset the search starts at index 0.
REQ-018 On acceptance, grant_id SHALL update to the winner in the same edge; data latched into a shift register; state -> START.
REQ-019 tx SHALL be low for exactly DIV cycles in START, beginning the cycle after acceptance.
REQ-020 DATA SHALL drive bits 0..7 LSB first, each for exactly DIV cycles.
REQ-021 STOP SHALL drive tx high for DIV cycles, then return to IDLE; start-to-start spacing of back-to-back frames = 10*DIV+1 cycles.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 LINE_LOCK=1: accepting a byte other than 0x0A sets locked; accepting 0x0A clears locked; 0x0D is treated as an ordinary byte.
REQ-024 While locked, owner dropping req_valid SHALL NOT release the lock; others wait indefinitely.
REQ-025 LINE_LOCK=0: locked SHALL stay 0 permanently.
REQ-026 Changes on req_valid/req_data outside the acceptance edge SHALL NOT affect a frame in flight.
REQ-027 Simultaneous requests in IDLE SHALL be resolved within the same cycle; no idle cycle inserted beyond REQ-021.

Reset
REQ-028 While rst_n low at a rising edge: state IDLE, tx=1, req_ready=0, busy=0, grant_id=0, locked=0, timer and bit index 0, round-robin pointer set so index 0 has highest priority.
REQ-029 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the next edge; the partial byte is dropped, not resent.
REQ-030 First acceptance possible in the first cycle after rst_n returns high.

Verification
REQ-031 DIV=10, req 1 sends 0x55 alone -> tx low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, high 10 cycles; req_ready[1] one pulse; grant_id=1.
REQ-032 LINE_LOCK=0, reqs 0 and 2 hold valid continuously -> accepted order 0,2,0,2; start-to-start spacing 101 cycles.
REQ-033 LINE_LOCK=1, req 0 sends "AB\n", req 3 valid throughout -> bytes 0x41,0x42,0x0A from req 0 before any req 3 byte; locked falls on 0x0A acceptance.
REQ-034 Locked owner idles 500 cycles with others valid -> no req_ready to others, tx stays 1, locked stays 1.
REQ-035 rst_n low during DATA bit 3 -> tx=1, busy=0, locked=0, grant_id=0 next edge; next request served starting from index 0 priority.
REQ-036 Receive-side checker at DIV=10 decodes each frame back to the sent byte for all 256 values from one requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Serial byte transmitter shared by NREQ requesters: round-robin arbitration with optional
// line lock held until the owner sends a newline, then one 8N1 frame per accepted byte.
//   state | meaning
//   IDLE  | line high, arbitration open, one req_ready pulse per accepted byte
//   START | start bit (low) for DIV cycles
//   DATA  | bits 0..7 of the latched byte, LSB first, DIV cycles each
//   STOP  | stop bit (high) for DIV cycles, then back to IDLE
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DIV       = 10,
  parameter bit LINE_LOCK = 1'b1,
  localparam int GW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              uart_clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              locked
);

  localparam int TW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [GW-1:0]   rr_ptr;
  logic [NREQ-1:0] eligible;
  logic [2*NREQ-1:0] elig_dbl;
  logic [NREQ-1:0] elig_rot;
  logic            found;
  logic [GW-1:0]   offset;
  logic [GW:0]     win_sum;
  logic [GW-1:0]   win;
  logic [7:0]      win_data;
  logic            accept;
  logic            bit_end;

  // Rotate the eligible set so the round-robin start index sits at bit 0.
  always_comb begin
    eligible = req_valid;
    if (locked) begin
      eligible = req_valid & (NREQ'(1) << grant_id);
    end
    elig_dbl = {eligible, eligible} >> rr_ptr;
    elig_rot = elig_dbl[NREQ-1:0];
    found    = 1'b0;
    offset   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig_rot[k]) begin
        found  = 1'b1;
        offset = GW'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= (GW+1)'(NREQ)) begin
      win_sum = win_sum - (GW+1)'(NREQ);
    end
    win      = win_sum[GW-1:0];
    win_data = 8'(req_data >> {win, 3'b000});
  end

  assign accept    = (state == IDLE) && found && rst_n;
  assign req_ready = accept ? (NREQ'(1) << win) : '0;
  assign bit_end   = (timer == TW'(DIV - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
    end else begin
      if ((state == IDLE) || bit_end) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if ((state == DATA) && bit_end) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (accept) begin
        shreg    <= win_data;
        grant_id <= win;
        rr_ptr   <= (win == GW'(NREQ - 1)) ? '0 : win + 1'b1;
        locked   <= LINE_LOCK && (win_data != 8'h0A);
      end
    end
  end

endmodule
